// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC writeback slice.
//   OP_MEM         op field value of memory-format instructions
//   OP3_STORE_BIT  op3 bit that separates stores (1) from loads (0)
//   wb_state_e     writeback sequencer states
//   icc_t          integer condition codes {n, z, v, c}
//   is_load()      source-select helper used by the writeback stage
package sparc_pkg;

  localparam logic [1:0]  OP_MEM        = 2'b11;
  localparam int unsigned OP3_STORE_BIT = 2;

  typedef enum logic [0:0] {
    WB_IDLE,
    WB_ODD
  } wb_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } icc_t;

  function automatic logic is_load(input logic [1:0] op, input logic [5:0] op3);
    return (op == OP_MEM) && !op3[OP3_STORE_BIT];
  endfunction

endpackage

// File: rtl/sparc_writeback.sv
// SPARC writeback stage. Consumes MEM/WB pipeline register outputs and drives the integer
// register-file write port, sequencing LDD-style double writes over two cycles with an upstream
// stall. Owns the architectural ICC and Y registers and exports the current write as a bypass.
//
// Optional build macro: WB_RETIRE_CNT_EN adds a 32-bit retire_cnt output.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wb_alures           ALU result ([31:0] single, [63:32]/[31:0] double)
//   wb_load_data        load data (even word [63:32], odd word [31:0])
//   wb_regD             destination rd
//   wb_op, wb_op3       instruction fields used for source select
//   wb_regWrite         rd write request
//   wb_regWriteDouble   double-word write request (qualified by wb_regWrite)
//   wb_icc/_write       new condition codes and update strobe
//   wb_Y/_write         new Y value and update strobe
//   rf_we/waddr/wdata   register-file write port
//   wb_stall            freezes upstream during the first cycle of a double write
//   fwd_valid/rd/data   bypass source, mirrors the register-file write port
//   icc_q, y_q          architectural ICC and Y
//   retire_cnt          (WB_RETIRE_CNT_EN only) count of retiring instructions
module sparc_writeback
  import sparc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*DATA_W-1:0]   wb_alures,
  input  logic [2*DATA_W-1:0]   wb_load_data,
  input  logic [REG_AW-1:0]     wb_regD,
  input  logic [1:0]            wb_op,
  input  logic [5:0]            wb_op3,
  input  logic                  wb_regWrite,
  input  logic                  wb_regWriteDouble,
  input  logic [3:0]            wb_icc,
  input  logic                  wb_icc_write,
  input  logic [31:0]           wb_Y,
  input  logic                  wb_Y_write,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  wb_stall,
  output logic                  fwd_valid,
  output logic [REG_AW-1:0]     fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [3:0]            icc_q,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]           y_q,
  output logic [31:0]           retire_cnt
`else
  output logic [31:0]           y_q
`endif
);

  wb_state_e            state_q, state_d;
  logic [REG_AW-1:0]    odd_addr_q, odd_addr_d;
  logic [DATA_W-1:0]    odd_data_q, odd_data_d;
  icc_t                 icc_r;
  logic [2*DATA_W-1:0]  src;
  logic [REG_AW-1:0]    even_addr;
  logic                 start_double;

  assign src          = is_load(wb_op, wb_op3) ? wb_load_data : wb_alures;
  // Double writes are forced to an even/odd register pair; rd[0] is ignored.
  assign even_addr    = {wb_regD[REG_AW-1:1], 1'b0};
  assign start_double = wb_regWrite && wb_regWriteDouble;

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WB_IDLE;
      odd_addr_q <= '0;
      odd_data_q <= '0;
      icc_r      <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      odd_addr_q <= odd_addr_d;
      odd_data_q <= odd_data_d;
      // Side effects commit once per instruction: the ODD cycle sees a held copy of the double.
      if (state_q == WB_IDLE) begin
        if (wb_icc_write) icc_r <= wb_icc;
        if (wb_Y_write)   y_q   <= wb_Y;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    odd_addr_d = odd_addr_q;
    odd_data_d = odd_data_q;
    case (state_q)
      WB_IDLE: begin
        if (start_double) begin
          state_d    = WB_ODD;
          odd_addr_d = {wb_regD[REG_AW-1:1], 1'b1};
          odd_data_d = src[DATA_W-1:0];
        end
      end
      WB_ODD:  state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // Write-port outputs
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    wb_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        WB_IDLE: begin
          if (start_double) begin
            rf_waddr = even_addr;
            rf_wdata = src[2*DATA_W-1:DATA_W];
            wb_stall = 1'b1;
          end else if (wb_regWrite) begin
            rf_waddr = wb_regD;
            rf_wdata = src[DATA_W-1:0];
          end
          // %g0 is hard-wired to zero: address and data stay visible, the enable does not.
          rf_we = wb_regWrite && (rf_waddr != '0);
        end
        WB_ODD: begin
          rf_waddr = odd_addr_q;
          rf_wdata = odd_data_q;
          rf_we    = (odd_addr_q != '0);
        end
        default: ;
      endcase
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
  assign icc_q     = icc_r;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if ((state_q == WB_IDLE) && (wb_regWrite || wb_icc_write || wb_Y_write)) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sparc_writeback.sv
module tb_sparc_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] wb_alures, wb_load_data;
  logic [4:0]  wb_regD;
  logic [1:0]  wb_op;
  logic [5:0]  wb_op3;
  logic        wb_regWrite, wb_regWriteDouble;
  logic [3:0]  wb_icc;
  logic        wb_icc_write;
  logic [31:0] wb_Y;
  logic        wb_Y_write;
  logic        rf_we, wb_stall, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data, y_q;
  logic [3:0]  icc_q;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: one pending odd write plus architectural state.
  bit          m_pend;
  logic [4:0]  m_paddr;
  logic [31:0] m_pdata;
  logic [3:0]  m_icc;
  logic [31:0] m_y;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  sparc_writeback #(.DATA_W(32), .REG_AW(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_alures         (wb_alures),
    .wb_load_data      (wb_load_data),
    .wb_regD           (wb_regD),
    .wb_op             (wb_op),
    .wb_op3            (wb_op3),
    .wb_regWrite       (wb_regWrite),
    .wb_regWriteDouble (wb_regWriteDouble),
    .wb_icc            (wb_icc),
    .wb_icc_write      (wb_icc_write),
    .wb_Y              (wb_Y),
    .wb_Y_write        (wb_Y_write),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_stall          (wb_stall),
    .fwd_valid         (fwd_valid),
    .fwd_rd            (fwd_rd),
    .fwd_data          (fwd_data),
    .icc_q             (icc_q),
`ifdef WB_RETIRE_CNT_EN
    .y_q               (y_q),
    .retire_cnt        (retire_cnt)
`else
    .y_q               (y_q)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] op, input logic [5:0] op3,
                       input logic [4:0] rd, input logic rw, input logic rwd,
                       input logic [63:0] alu, input logic [63:0] ld,
                       input logic iccw, input logic [3:0] icc,
                       input logic yw, input logic [31:0] y);
    reset = rst; wb_op = op; wb_op3 = op3; wb_regD = rd;
    wb_regWrite = rw; wb_regWriteDouble = rwd;
    wb_alures = alu; wb_load_data = ld;
    wb_icc_write = iccw; wb_icc = icc; wb_Y_write = yw; wb_Y = y;
  endtask

  // Compare one cycle against the model, then advance the model across the clock edge.
  task automatic cycle();
    logic        e_we, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [63:0] src;
    #1;
    e_stall = 1'b0; e_addr = '0; e_data = '0;
    src = (wb_op == 2'b11 && wb_op3[2] == 1'b0) ? wb_load_data : wb_alures;
    if (reset) begin
      // everything zero
    end else if (m_pend) begin
      e_addr = m_paddr; e_data = m_pdata;
    end else if (wb_regWrite && wb_regWriteDouble) begin
      e_addr = {wb_regD[4:1], 1'b0}; e_data = src[63:32]; e_stall = 1'b1;
    end else if (wb_regWrite) begin
      e_addr = wb_regD; e_data = src[31:0];
    end
    e_we = !reset && (m_pend || wb_regWrite) && (e_addr != 5'd0);
    check("rf_we",     64'(rf_we),     64'(e_we));
    check("rf_waddr",  64'(rf_waddr),  64'(e_addr));
    check("rf_wdata",  64'(rf_wdata),  64'(e_data));
    check("wb_stall",  64'(wb_stall),  64'(e_stall));
    check("fwd_valid", 64'(fwd_valid), 64'(e_we));
    check("fwd_rd",    64'(fwd_rd),    64'(e_addr));
    check("fwd_data",  64'(fwd_data),  64'(e_data));
    check("icc_q",     64'(icc_q),     64'(m_icc));
    check("y_q",       64'(y_q),       64'(m_y));
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
`endif
    if (reset) begin
      m_pend = 0; m_paddr = '0; m_pdata = '0; m_icc = '0; m_y = '0; m_cnt = '0;
    end else if (m_pend) begin
      m_pend = 0;
    end else begin
      if (wb_icc_write) m_icc = wb_icc;
      if (wb_Y_write)   m_y   = wb_Y;
      if (wb_regWrite || wb_icc_write || wb_Y_write) m_cnt = m_cnt + 32'd1;
      if (wb_regWrite && wb_regWriteDouble) begin
        m_pend = 1; m_paddr = {wb_regD[4:1], 1'b1}; m_pdata = src[31:0];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 2'b00, 6'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    m_pend = 0; m_paddr = '0; m_pdata = '0; m_icc = '0; m_y = '0; m_cnt = '0;
    // Reset held: outputs forced low, registers at zero.
    drive(1'b1, 2'b10, 6'd0, 5'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
          1'b1, 4'hF, 1'b1, 32'hFFFF_FFFF);
    cycle();

    // ALU single write
    drive(1'b0, 2'b10, 6'd0, 5'd5, 1'b1, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'd0,
          1'b0, 4'd0, 1'b0, 32'd0);
    #1 check("alu_wdata", 64'(rf_wdata), 64'h0000_0000_DEAD_BEEF);
    cycle();

    // Load single, then a store with no register write
    drive(1'b0, 2'b11, 6'b000000, 5'd9, 1'b1, 1'b0, 64'h1111_2222_3333_4444,
          64'h9999_8888_1234_5678, 1'b0, 4'd0, 1'b0, 32'd0);
    #1 check("ld_wdata", 64'(rf_wdata), 64'h1234_5678);
    cycle();
    drive(1'b0, 2'b11, 6'b000100, 5'd9, 1'b0, 1'b0, 64'd0, 64'h9999_8888_1234_5678,
          1'b0, 4'd0, 1'b0, 32'd0);
    cycle();

    // LDD rd=7: even word to r6 with stall, odd word to r7, then idle
    drive(1'b0, 2'b11, 6'b000011, 5'd7, 1'b1, 1'b1, 64'd0, 64'hAAAA_AAAA_5555_5555,
          1'b0, 4'd0, 1'b0, 32'd0);
    #1 check("ldd_c0_addr", 64'(rf_waddr), 64'd6);
    cycle();
    check("ldd_c1_addr", 64'(rf_waddr), 64'd7);
    check("ldd_c1_data", 64'(rf_wdata), 64'h5555_5555);
    cycle();
    drive(1'b0, 2'b00, 6'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0, 32'd0);
    cycle();

    // %g0 single write, then LDD to r0/r1
    drive(1'b0, 2'b10, 6'd0, 5'd0, 1'b1, 1'b0, 64'h0000_0000_CAFE_F00D, 64'd0,
          1'b0, 4'd0, 1'b0, 32'd0);
    cycle();
    drive(1'b0, 2'b11, 6'b000011, 5'd0, 1'b1, 1'b1, 64'd0, 64'h0123_4567_89AB_CDEF,
          1'b0, 4'd0, 1'b0, 32'd0);
    cycle();
    cycle();

    // ICC/Y with a concurrent register write; then Y must hold
    drive(1'b0, 2'b10, 6'd0, 5'd3, 1'b1, 1'b0, 64'h0000_0000_0000_0042, 64'd0,
          1'b1, 4'b0101, 1'b1, 32'h0000_1234);
    cycle();
    check("icc_plan", 64'(icc_q), 64'h5);
    drive(1'b0, 2'b10, 6'd0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0, 32'hBAD0_BAD0);
    cycle();
    check("y_hold", 64'(y_q), 64'h1234);

    // Reset during the ODD cycle drops the odd write
    drive(1'b0, 2'b10, 6'd0, 5'd11, 1'b1, 1'b1, 64'h7777_6666_5555_4444, 64'd0,
          1'b1, 4'b1010, 1'b1, 32'h0000_9999);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wb_regWrite = 1'b0; wb_icc_write = 1'b0; wb_Y_write = 1'b0;
    cycle();

    // Randomized traffic; inputs also change during ODD to show they are ignored there
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 2'($urandom), 6'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 4'($urandom), 1'($urandom), $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sparc_writeback.md
Name: sparc_writeback

Overview:
- Writeback stage of the SPARC pipeline; consumes the MEM/WB pipeline register outputs directly.
- Selects the load or ALU result and drives the integer register-file write port, including 2-cycle double-word (LDD) sequencing with an upstream stall.
- Owns the architectural ICC and Y registers.
- Exports the current-cycle write as a forwarding source.

Parameters:
- DATA_W, 32, architectural register width.
- REG_AW, 5, register-file address width (window-relative rd).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- wb_alures  in  64  ALU result; [31:0] used for single writes, [63:32]/[31:0] for double writes.
- wb_load_data  in  64  load data; even word in [63:32], odd word in [31:0].
- wb_regD  in  REG_AW  destination register rd.
- wb_op  in  2  instruction op field.
- wb_op3  in  6  instruction op3 field.
- wb_regWrite  in  1  rd write request.
- wb_regWriteDouble  in  1  double-word write request (valid only with wb_regWrite).
- wb_icc  in  4  N,Z,V,C.
- wb_icc_write  in  1  ICC update.
- wb_Y  in  32  new Y value.
- wb_Y_write  in  1  Y update.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- wb_stall  out  1  freeze IF..MEM/WB; high during the first cycle of a double write.
- fwd_valid  out  1  equals rf_we; bypass source valid.
- fwd_rd  out  REG_AW  equals rf_waddr.
- fwd_data  out  DATA_W  equals rf_wdata.
- icc_q  out  4  architectural ICC.
- y_q  out  32  architectural Y.

Behaviour:
- Source select: is_load = (wb_op==2'b11) && (wb_op3[2]==0). Source word(s) come from wb_load_data if is_load, else from wb_alures.
- Single write (IDLE, regWrite=1, regWriteDouble=0): combinational, 0-cycle latency.
  - rf_we=1, rf_waddr=wb_regD, rf_wdata=src[31:0].
  - wb_stall=0.
- FSM states: IDLE, ODD.
- IDLE with regWrite && regWriteDouble:
  - This cycle: rf_waddr={wb_regD[4:1],1'b0}, rf_wdata=src[63:32], wb_stall=1.
  - Latch odd_addr={wb_regD[4:1],1'b1} and odd_data=src[31:0]; go to ODD.
  - rd[0] is ignored (even alignment forced).
- ODD: rf_we=1, rf_waddr=odd_addr, rf_wdata=odd_data, wb_stall=0.
  - Inputs are ignored in ODD. Upstream holds during the stall, so the MEM/WB contents in this cycle are the same double instruction.
  - Always returns to IDLE after one cycle.
- %g0 rule: any write with address 0 forces rf_we=0 (rf_waddr/rf_wdata still driven). For a double with rd=0, only r1 is written.
- ICC: icc_q <= wb_icc when wb_icc_write, sampled in IDLE only.
- Y: y_q <= wb_Y when wb_Y_write, sampled in IDLE only.
  - Both updates happen on the first cycle of a double; they are not repeated in ODD.
  - Simultaneous ICC, Y and rf writes all commit in the same cycle.
- Idle/NOP (regWrite=0): rf_we=0, rf_waddr=0, rf_wdata=0, wb_stall=0.
- Reset (any state, including mid-ODD):
  - At the edge: state=IDLE, icc_q=0, y_q=0, odd_addr/odd_data=0.
  - While reset is high: rf_we, wb_stall and fwd_valid are forced 0, rf_waddr/rf_wdata are 0.
  - A pending odd write is discarded.
- fwd_* mirror rf_* every cycle, including the %g0 suppression.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt (32 bits), a register reset to 0.
  - Increments by 1 on each IDLE cycle where regWrite|wb_icc_write|wb_Y_write is set.
  - A double counts once (on its first cycle). Writes to %g0 still count.
  - Wraps 0xFFFFFFFF->0.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sparc_pkg holds:
  - OP_MEM=2'b11 and the op3 store-bit index.
  - The wb_state_e enum {WB_IDLE, WB_ODD}.
  - The icc_t packed struct {n,z,v,c}.
- No sub-module is needed. The FSM, the ICC/Y registers and the counter stay in one module.

Test Plan:
- ALU single write: op=2'b10, rd=5, alures=0x0000_0000_DEAD_BEEF, regWrite=1 -> same cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, wb_stall=0.
- Load single: op=2'b11, op3=6'b000000, rd=9, load_data=0x...1234_5678 -> wdata=0x12345678; same with op3=6'b000100 (store) and regWrite=0 -> rf_we=0.
- LDD: op3=6'b000011, rd=7, load_data=0xAAAA_AAAA_5555_5555 ->
  - cycle0: waddr=6, wdata=0xAAAAAAAA, wb_stall=1;
  - cycle1: waddr=7, wdata=0x55555555, wb_stall=0;
  - cycle2: back in IDLE.
- %g0: single write rd=0 -> rf_we=0; LDD rd=0 -> cycle0 rf_we=0 with wb_stall=1, cycle1 writes r1.
- ICC/Y: icc_write=1, icc=4'b0101, Y_write=1, Y=0x1234 with a concurrent rf write -> next cycle icc_q=0101, y_q=0x1234, rf write also observed; Y_write=0 afterwards -> y_q holds.
- Reset mid-double: assert reset in the ODD cycle -> no odd write, wb_stall=0, icc_q=0, y_q=0, state=IDLE; with WB_RETIRE_CNT_EN, retire_cnt=0.
